// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial transmitter/receiver pair.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package bs_pkg;

    // Shifter sequencing states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_GAPWAIT = 2'd2
    } bs_state_e;

    localparam int BS_WIDTH = 8;   // default word width
    localparam int BS_GAP_W = 4;   // width of the inter-word gap counter

    // Bit-counter width: must hold values 0..width.
    function automatic int bs_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bs_hold_reg.sv
// One-entry valid/ready holding buffer (data register + full flag).
// Latency: a word accepted in cycle T is visible on out_data/full in cycle T+1.
// Backpressure: in_ready = !full, registered only; never depends on in_valid.
// Ports: clk, rst_n (sync, active low); in_data/in_valid/in_ready upstream side;
//        pop empties the entry (only meaningful while full); out_data/full downstream.
module bs_hold_reg
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    logic push;

    // A push can only happen while empty and a pop only while full, so the
    // two never coincide; a freed entry is not refilled in the same cycle.
    assign push     = in_valid && !full;
    assign in_ready = !full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 1'b0;
            out_data <= '0;
        end else begin
            if (push) begin
                full     <= 1'b1;
                out_data <= in_data;
            end else if (pop) begin
                full     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bit_serial_tx.sv
// Parallel-to-bit-serial word transmitter with sow/eow strobes.
// Latency: word accepted in cycle T (shifter idle) shows its first bit in cycle T+2.
// Backpressure: in_ready = holding buffer empty; ser_stall freezes serial outputs and shifter.
// Ports: clk, rst_n (sync, active low); in_data/in_valid/in_ready word input;
//        ser_stall downstream pause; ser_bit/ser_valid/ser_sow/ser_eow serial output;
//        busy = shifter or buffer occupied or gap countdown running.
module bit_serial_tx
    import bs_pkg::*;
#(
    parameter int WIDTH     = BS_WIDTH,
    parameter int LSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_stall,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_sow,
    output logic             ser_eow,
    output logic             busy
);

    localparam int                  CW     = bs_cnt_w(WIDTH);
    localparam logic [CW-1:0]       LAST   = CW'(WIDTH - 1);
    localparam logic [BS_GAP_W-1:0] GAP_LD = BS_GAP_W'(GAP);

    bs_state_e            state, state_nxt;
    logic [WIDTH-1:0]     sr, sr_nxt, sr_shifted;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BS_GAP_W-1:0]  gap_cnt, gap_nxt;
    logic                 hb_full, hb_pop;
    logic [WIDTH-1:0]     hb_data;
    logic                 bit_nxt;

    bs_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pop      (hb_pop),
        .out_data (hb_data),
        .full     (hb_full)
    );

    // The output end of SR is bit 0 for LSB-first, bit WIDTH-1 otherwise.
    assign sr_shifted = (LSB_FIRST != 0) ? (sr >> 1) : (sr << 1);

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        hb_pop    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // Starting a word changes ser_valid, so it waits out a stall.
                if (hb_full && gap_cnt == '0 && !ser_stall) begin
                    state_nxt = ST_SHIFT;
                    sr_nxt    = hb_data;
                    cnt_nxt   = '0;
                    hb_pop    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!ser_stall) begin
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
                        if (GAP != 0) begin
                            state_nxt = ST_GAPWAIT;
                            gap_nxt   = GAP_LD;
                        end else if (hb_full) begin
                            // Reload straight from the buffer: no bubble.
                            sr_nxt = hb_data;
                            hb_pop = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        sr_nxt  = sr_shifted;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            ST_GAPWAIT: begin
                // Gap time runs regardless of stall; the cycle that brings
                // the count to zero applies the same start rule as IDLE.
                gap_nxt = (gap_cnt != '0) ? gap_cnt - BS_GAP_W'(1) : '0;
                if (gap_cnt <= BS_GAP_W'(1)) begin
                    if (hb_full && !ser_stall) begin
                        state_nxt = ST_SHIFT;
                        sr_nxt    = hb_data;
                        cnt_nxt   = '0;
                        hb_pop    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        bit_nxt = (LSB_FIRST != 0) ? sr_nxt[0] : sr_nxt[WIDTH-1];
    end

    // Outputs are registered from next-state values, so a stall (which
    // holds every next value) leaves them frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sr        <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_sow   <= 1'b0;
            ser_eow   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            cnt       <= cnt_nxt;
            gap_cnt   <= gap_nxt;
            ser_valid <= (state_nxt == ST_SHIFT);
            ser_bit   <= (state_nxt == ST_SHIFT) && bit_nxt;
            ser_sow   <= (state_nxt == ST_SHIFT) && (cnt_nxt == '0);
            ser_eow   <= (state_nxt == ST_SHIFT) && (cnt_nxt == LAST);
        end
    end

    assign busy = (state != ST_IDLE) || hb_full;

endmodule
